// File: rtl/axi_line_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_line_mover                                            |
// | Brief    : moves whole cache lines over AXI4 (writeback + refill)    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module axi_line_mover #(
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wb_start,
  input  logic [ADDR_WIDTH-1:0]                wb_addr,
  input  logic [(2**BLOCK_SIZE)*DATA_SIZE-1:0] wb_data,
  input  logic                                 rf_start,
  input  logic [ADDR_WIDTH-1:0]                rf_addr,
  output logic [(2**BLOCK_SIZE)*DATA_SIZE-1:0] rf_data,
  output logic                                 wb_done,
  output logic                                 rf_done,
  output logic                                 wb_err,
  output logic                                 rf_err,
  output logic                                 busy,
  output logic [ADDR_WIDTH-1:0]                awaddr,
  output logic [7:0]                           awlen,
  output logic [2:0]                           awsize,
  output logic [1:0]                           awburst,
  output logic                                 awvalid,
  input  logic                                 awready,
  output logic [DATA_SIZE-1:0]                 wdata,
  output logic [DATA_SIZE/8-1:0]               wstrb,
  output logic                                 wlast,
  output logic                                 wvalid,
  input  logic                                 wready,
  input  logic [1:0]                           bresp,
  input  logic                                 bvalid,
  output logic                                 bready,
  output logic [ADDR_WIDTH-1:0]                araddr,
  output logic [7:0]                           arlen,
  output logic [2:0]                           arsize,
  output logic [1:0]                           arburst,
  output logic                                 arvalid,
  input  logic                                 arready,
  input  logic [DATA_SIZE-1:0]                 rdata,
  input  logic [1:0]                           rresp,
  input  logic                                 rlast,
  input  logic                                 rvalid,
  output logic                                 rready
);

  localparam int                    c_BLOCKS = 2**BLOCK_SIZE;
  localparam int                    c_OFF    = BLOCK_SIZE + $clog2(DATA_SIZE / 8);
  localparam logic [BLOCK_SIZE-1:0] c_LAST   = BLOCK_SIZE'(c_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB_AW = 3'd1,
    S_WB_W  = 3'd2,
    S_WB_B  = 3'd3,
    S_RF_AR = 3'd4,
    S_RF_R  = 3'd5
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [BLOCK_SIZE-1:0]   r_beat, w_beat_nxt, w_beat_inc;
  logic                    w_beat_last;
  logic                    r_awvalid, w_awvalid_nxt;
  logic                    r_wvalid, w_wvalid_nxt;
  logic                    r_wlast, w_wlast_nxt;
  logic [DATA_SIZE-1:0]    r_wdata, w_wdata_nxt;
  logic                    r_bready, w_bready_nxt;
  logic                    r_arvalid, w_arvalid_nxt;
  logic                    r_rready, w_rready_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_wb_done, w_wb_done_nxt;
  logic                    r_rf_done, w_rf_done_nxt;
  logic                    r_wb_err, w_wb_err_nxt;
  logic                    r_rf_err, w_rf_err_nxt;
  logic                    r_rf_pending, w_pending_nxt;
  logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
  logic                    w_wb_cap, w_rf_cap, w_r_hs;
  logic [DATA_SIZE-1:0]    r_wb_mem [c_BLOCKS];
  logic [DATA_SIZE-1:0]    r_rf_mem [c_BLOCKS];
  logic                    w_unused_ok;

  assign w_beat_inc  = r_beat + 1'b1;
  assign w_beat_last = (r_beat == c_LAST);
  assign w_r_hs      = (r_state == S_RF_R) && rvalid;
  assign w_unused_ok = &{1'b0, bresp[0], rresp[0], wb_addr[c_OFF-1:0], rf_addr[c_OFF-1:0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_wlast_nxt   = r_wlast;
    w_wdata_nxt   = r_wdata;
    w_bready_nxt  = r_bready;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_busy_nxt    = r_busy;
    w_wb_done_nxt = 1'b0;
    w_rf_done_nxt = 1'b0;
    w_wb_err_nxt  = r_wb_err;
    w_rf_err_nxt  = r_rf_err;
    w_pending_nxt = r_rf_pending;
    w_wb_cap      = 1'b0;
    w_rf_cap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Simultaneous requests: writeback first, refill parked in rf_pending.
        if (wb_start) begin
          w_wb_cap      = 1'b1;
          w_wb_err_nxt  = 1'b0;
          w_awvalid_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_WB_AW;
          if (rf_start) begin
            w_rf_cap      = 1'b1;
            w_rf_err_nxt  = 1'b0;
            w_pending_nxt = 1'b1;
          end
        end else if (rf_start) begin
          w_rf_cap      = 1'b1;
          w_rf_err_nxt  = 1'b0;
          w_arvalid_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_RF_AR;
        end
      end
      S_WB_AW: begin
        if (awready) begin
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b1;
          w_beat_nxt    = '0;
          w_wdata_nxt   = r_wb_mem[{BLOCK_SIZE{1'b0}}];
          w_wlast_nxt   = (c_BLOCKS == 1);
          w_state_nxt   = S_WB_W;
        end
      end
      S_WB_W: begin
        if (wready) begin
          if (r_wlast) begin
            w_wvalid_nxt = 1'b0;
            w_wlast_nxt  = 1'b0;
            w_bready_nxt = 1'b1;
            w_state_nxt  = S_WB_B;
          end else begin
            w_beat_nxt  = w_beat_inc;
            w_wdata_nxt = r_wb_mem[w_beat_inc];
            w_wlast_nxt = (w_beat_inc == c_LAST);
          end
        end
      end
      S_WB_B: begin
        if (bvalid) begin
          w_bready_nxt  = 1'b0;
          w_wb_err_nxt  = bresp[1];
          w_wb_done_nxt = 1'b1;
          if (r_rf_pending) begin
            w_pending_nxt = 1'b0;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RF_AR;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RF_AR: begin
        if (arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_beat_nxt    = '0;
          w_state_nxt   = S_RF_R;
        end
      end
      S_RF_R: begin
        if (rvalid) begin
          // A burst whose rlast disagrees with the beat count is flagged but still closed.
          w_rf_err_nxt = r_rf_err | rresp[1] | (rlast != w_beat_last);
          if (rlast || w_beat_last) begin
            w_rready_nxt  = 1'b0;
            w_rf_done_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_beat_nxt    = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_beat_nxt = w_beat_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_wdata      <= '0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_busy       <= 1'b0;
      r_wb_done    <= 1'b0;
      r_rf_done    <= 1'b0;
      r_wb_err     <= 1'b0;
      r_rf_err     <= 1'b0;
      r_rf_pending <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      for (int i = 0; i < c_BLOCKS; i++) r_rf_mem[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_wlast      <= w_wlast_nxt;
      r_wdata      <= w_wdata_nxt;
      r_bready     <= w_bready_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_busy       <= w_busy_nxt;
      r_wb_done    <= w_wb_done_nxt;
      r_rf_done    <= w_rf_done_nxt;
      r_wb_err     <= w_wb_err_nxt;
      r_rf_err     <= w_rf_err_nxt;
      r_rf_pending <= w_pending_nxt;
      if (w_wb_cap) r_awaddr <= {wb_addr[ADDR_WIDTH-1:c_OFF], {c_OFF{1'b0}}};
      if (w_rf_cap) r_araddr <= {rf_addr[ADDR_WIDTH-1:c_OFF], {c_OFF{1'b0}}};
      if (w_r_hs)   r_rf_mem[r_beat] <= rdata;
    end
  end

  // Victim line storage is pure datapath; contents are only read after a capture.
  always_ff @(posedge clk) begin
    if (w_wb_cap) begin
      for (int i = 0; i < c_BLOCKS; i++) r_wb_mem[i] <= wb_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  generate
    for (genvar g = 0; g < c_BLOCKS; g++) begin : g_rf_pack
      assign rf_data[g*DATA_SIZE +: DATA_SIZE] = r_rf_mem[g];
    end
  endgenerate

  assign awaddr  = r_awaddr;
  assign awlen   = 8'(c_BLOCKS - 1);
  assign awsize  = 3'($clog2(DATA_SIZE / 8));
  assign awburst = 2'b01;
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata;
  assign wstrb   = '1;
  assign wlast   = r_wlast;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;
  assign araddr  = r_araddr;
  assign arlen   = 8'(c_BLOCKS - 1);
  assign arsize  = 3'($clog2(DATA_SIZE / 8));
  assign arburst = 2'b01;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign busy    = r_busy;
  assign wb_done = r_wb_done;
  assign rf_done = r_rf_done;
  assign wb_err  = r_wb_err;
  assign rf_err  = r_rf_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_line_mover.sv
`default_nettype none
// Bench for axi_line_mover: randomized AXI slave plus a line-level model of
// burst contents, aligned addresses and cycle latency.
module tb_axi_line_mover;
  localparam int DS = 32, BS = 6, AW = 32, NB = 1 << BS;
  localparam logic [AW-1:0] LINE_MASK = ~AW'(NB * DS / 8 - 1);

  logic clk = 0, rst_n = 0;
  logic wb_start = 0, rf_start = 0;
  logic [AW-1:0] wb_addr = '0, rf_addr = '0;
  logic [NB*DS-1:0] wb_data = '0;
  logic [NB*DS-1:0] rf_data;
  logic wb_done, rf_done, wb_err, rf_err, busy;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awvalid, wvalid, wlast, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 0;
  logic [DS-1:0] wdata;
  logic [DS/8-1:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  logic [DS-1:0] rdata = '0;

  axi_line_mover #(.DATA_SIZE(DS), .BLOCK_SIZE(BS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_start(wb_start), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_start(rf_start), .rf_addr(rf_addr), .rf_data(rf_data), .wb_done(wb_done),
    .rf_done(rf_done), .wb_err(wb_err), .rf_err(rf_err), .busy(busy),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [DS-1:0] wb_words [NB];
  logic [DS-1:0] rword [NB];
  logic [DS-1:0] exp_line [NB];
  logic [DS-1:0] wr_seen [$];
  int wlast_beat, wlast_cnt, stable_bad, stalls, busy_bad, rbeats_sent;
  int wb_done_cyc, rf_done_cyc, ar_first_cyc;
  logic busy_at_end, wb_err_obs, rf_err_obs;
  logic [AW-1:0] aw_seen, ar_seen;
  bit timeout;

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) >= pct);
  endfunction

  task automatic load_wb();
    for (int i = 0; i < NB; i++) wb_data[i*DS +: DS] = wb_words[i];
  endtask

  task automatic idle_inputs();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
    bresp = 0; rresp = 0; wb_start = 0; rf_start = 0;
  endtask

  // AXI slave + observer. Called at the negedge where the start inputs were set.
  task automatic run_bus(input int pct, input bit need_wb, input bit need_rf,
                         input int rlast_at, input logic [1:0] bresp_v, input int abort_w);
    int cyc, wbeats;
    bit b_due, r_on, prev_stall;
    logic [DS-1:0] prev_wdata;
    logic prev_wlast;
    wr_seen.delete();
    wlast_beat = -1; wlast_cnt = 0; stable_bad = 0; stalls = 0; busy_bad = 0;
    rbeats_sent = 0; wb_done_cyc = -1; rf_done_cyc = -1; ar_first_cyc = -1;
    busy_at_end = 1'bx; wb_err_obs = 1'bx; rf_err_obs = 1'bx; timeout = 0;
    aw_seen = 'x; ar_seen = 'x;
    wbeats = 0; b_due = 0; r_on = 0; prev_stall = 0; prev_wdata = '0; prev_wlast = 0;
    @(negedge clk);
    cyc = 1; wb_start = 0; rf_start = 0;
    forever begin
      if (prev_stall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast)) stable_bad++;
      if (wb_done) begin wb_done_cyc = cyc; wb_err_obs = wb_err; end
      if (rf_done) begin rf_done_cyc = cyc; rf_err_obs = rf_err; end
      if (arvalid && ar_first_cyc < 0) ar_first_cyc = cyc;
      if ((!need_wb || wb_done_cyc >= 0) && (!need_rf || rf_done_cyc >= 0)) begin
        busy_at_end = busy;
        break;
      end
      if (!busy) busy_bad++;
      if (abort_w >= 0 && wvalid && wbeats == abort_w) break;
      if (cyc > 5000) begin timeout = 1; break; end
      awready = rnd(pct); wready = rnd(pct); arready = rnd(pct);
      bvalid = b_due && rnd(pct); bresp = bresp_v;
      rvalid = r_on && rnd(pct); rresp = 2'b00;
      rdata = (rbeats_sent < NB) ? rword[rbeats_sent] : '0;
      rlast = (rbeats_sent == rlast_at);
      if (awvalid && !awready) stalls++;
      if (wvalid && !wready) stalls++;
      if (bready && !bvalid) stalls++;
      if (arvalid && !arready) stalls++;
      if (rready && !rvalid) stalls++;
      if (awvalid && awready) aw_seen = awaddr;
      if (wvalid && wready) begin
        wr_seen.push_back(wdata);
        if (wlast) begin wlast_cnt++; wlast_beat = wbeats; b_due = 1; end
        wbeats++;
      end
      if (bready && bvalid) b_due = 0;
      if (arvalid && arready) begin ar_seen = araddr; r_on = 1; end
      if (rready && rvalid) begin
        rbeats_sent++;
        if (rbeats_sent > rlast_at) r_on = 0;
      end
      prev_stall = wvalid && !wready; prev_wdata = wdata; prev_wlast = wlast;
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    if (abort_w < 0) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, awvalid, wvalid, wlast, bready, arvalid, rready, wb_done, rf_done, wb_err, rf_err} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, awvalid, wvalid, wlast, bready, arvalid, rready, wb_done, rf_done, wb_err, rf_err});
    end
    vectors++;
    if (awaddr !== '0 || araddr !== '0 || wdata !== '0) begin
      miscompares++; $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h want 0", awaddr, araddr, wdata);
    end
    vectors++;
    if (rf_data !== '0) begin miscompares++; $display("FAIL reset_rf_data: nonzero=%b want 0", |rf_data); end
    vectors++;
    if ({awlen, awsize, awburst, arlen, arsize, arburst, wstrb} !== {8'd63, 3'd2, 2'b01, 8'd63, 3'd2, 2'b01, 4'hF}) begin
      miscompares++;
      $display("FAIL burst_attrs: awlen=%0d awsize=%0d awburst=%b arlen=%0d arsize=%0d arburst=%b wstrb=%h want 63/2/01/63/2/01/f",
               awlen, awsize, awburst, arlen, arsize, arburst, wstrb);
    end
    rst_n = 1;
    for (int i = 0; i < NB; i++) exp_line[i] = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_writeback();
    for (int i = 0; i < NB; i++) wb_words[i] = 32'hA500_0000 + i;
    load_wb(); wb_addr = 32'h0000_1234; wb_start = 1;
    run_bus(0, 1, 0, NB - 1, 2'b00, -1);
    vectors++;
    if (timeout) begin miscompares++; $display("FAIL wb_timeout: no wb_done within budget"); end
    vectors++;
    if (aw_seen !== 32'h0000_1200) begin miscompares++; $display("FAIL wb_awaddr: got %h want 00001200", aw_seen); end
    vectors++;
    if (wr_seen.size() != NB) begin miscompares++; $display("FAIL wb_beats: got %0d want %0d", wr_seen.size(), NB); end
    for (int i = 0; i < NB && i < wr_seen.size(); i++) begin
      vectors++;
      if (wr_seen[i] !== wb_words[i]) begin miscompares++; $display("FAIL wb_word[%0d]: got %h want %h", i, wr_seen[i], wb_words[i]); end
    end
    vectors++;
    if (wlast_beat != NB - 1 || wlast_cnt != 1) begin
      miscompares++; $display("FAIL wb_wlast: beat=%0d count=%0d want %0d/1", wlast_beat, wlast_cnt, NB - 1);
    end
    vectors++;
    if (wb_done_cyc != NB + 3) begin miscompares++; $display("FAIL wb_latency: got %0d want %0d", wb_done_cyc, NB + 3); end
    vectors++;
    if (wb_err_obs !== 1'b0 || busy_at_end !== 1'b0 || busy_bad != 0) begin
      miscompares++; $display("FAIL wb_status: err=%b busy_at_done=%b busy_gaps=%0d want 0/0/0", wb_err_obs, busy_at_end, busy_bad);
    end
  endtask

  task automatic test_refill();
    for (int i = 0; i < NB; i++) rword[i] = 32'hC0DE_0000 + i;
    rf_addr = $urandom; rf_start = 1;
    run_bus(0, 0, 1, NB - 1, 2'b00, -1);
    for (int k = 0; k < rbeats_sent; k++) exp_line[k] = rword[k];
    vectors++;
    if (timeout) begin miscompares++; $display("FAIL rf_timeout: no rf_done within budget"); end
    vectors++;
    if (ar_seen !== (rf_addr & LINE_MASK)) begin miscompares++; $display("FAIL rf_araddr: got %h want %h", ar_seen, rf_addr & LINE_MASK); end
    vectors++;
    if (rf_done_cyc != NB + 2) begin miscompares++; $display("FAIL rf_latency: got %0d want %0d", rf_done_cyc, NB + 2); end
    vectors++;
    if (rf_err_obs !== 1'b0 || busy_at_end !== 1'b0) begin
      miscompares++; $display("FAIL rf_status: err=%b busy_at_done=%b want 0/0", rf_err_obs, busy_at_end);
    end
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (rf_data[i*DS +: DS] !== exp_line[i]) begin miscompares++; $display("FAIL rf_word[%0d]: got %h want %h", i, rf_data[i*DS +: DS], exp_line[i]); end
    end
  endtask

  // Mode 0: writeback, 1: refill, 2: simultaneous writeback then refill.
  task automatic run_mixed(input int mode, input int pct, input string tag);
    int base;
    for (int i = 0; i < NB; i++) begin wb_words[i] = $urandom; rword[i] = $urandom; end
    load_wb(); wb_addr = $urandom; rf_addr = $urandom;
    wb_start = (mode != 1); rf_start = (mode != 0);
    run_bus(pct, mode != 1, mode != 0, NB - 1, 2'b00, -1);
    for (int k = 0; k < rbeats_sent; k++) exp_line[k] = rword[k];
    base = (mode == 0) ? NB + 3 : (mode == 1) ? NB + 2 : 2 * NB + 4;
    vectors++;
    if (timeout) begin miscompares++; $display("FAIL %s_timeout: transfer did not complete", tag); end
    vectors++;
    if (stable_bad != 0) begin miscompares++; $display("FAIL %s_w_stable: %0d unstable stall cycles want 0", tag, stable_bad); end
    vectors++;
    if ((mode == 1 ? rf_done_cyc : (mode == 0 ? wb_done_cyc : rf_done_cyc)) != base + stalls) begin
      miscompares++;
      $display("FAIL %s_latency: wb_done=%0d rf_done=%0d stalls=%0d want final=%0d", tag, wb_done_cyc, rf_done_cyc, stalls, base + stalls);
    end
    vectors++;
    if (busy_bad != 0 || busy_at_end !== 1'b0) begin
      miscompares++; $display("FAIL %s_busy: gaps=%0d busy_at_done=%b want 0/0", tag, busy_bad, busy_at_end);
    end
    if (mode != 1) begin
      vectors++;
      if (wr_seen.size() != NB || aw_seen !== (wb_addr & LINE_MASK)) begin
        miscompares++; $display("FAIL %s_aw: beats=%0d awaddr=%h want %0d/%h", tag, wr_seen.size(), aw_seen, NB, wb_addr & LINE_MASK);
      end
      for (int i = 0; i < NB && i < wr_seen.size(); i++) begin
        vectors++;
        if (wr_seen[i] !== wb_words[i]) begin miscompares++; $display("FAIL %s_wword[%0d]: got %h want %h", tag, i, wr_seen[i], wb_words[i]); end
      end
    end
    if (mode == 2) begin
      vectors++;
      if (ar_first_cyc != wb_done_cyc || ar_first_cyc < 0) begin
        miscompares++; $display("FAIL %s_chain: arvalid_cycle=%0d wb_done_cycle=%0d want equal", tag, ar_first_cyc, wb_done_cyc);
      end
    end
    if (mode != 0) begin
      vectors++;
      if (rf_err_obs !== 1'b0 || ar_seen !== (rf_addr & LINE_MASK)) begin
        miscompares++; $display("FAIL %s_rf: err=%b araddr=%h want 0/%h", tag, rf_err_obs, ar_seen, rf_addr & LINE_MASK);
      end
      for (int i = 0; i < NB; i++) begin
        vectors++;
        if (rf_data[i*DS +: DS] !== exp_line[i]) begin miscompares++; $display("FAIL %s_rword[%0d]: got %h want %h", tag, i, rf_data[i*DS +: DS], exp_line[i]); end
      end
    end
  endtask

  task automatic test_simultaneous();
    run_mixed(2, 0, "simul");
  endtask

  task automatic test_random_stalls();
    for (int it = 0; it < 6; it++) run_mixed(it % 3, 30, "stall");
  endtask

  task automatic test_errors();
    for (int i = 0; i < NB; i++) wb_words[i] = $urandom;
    load_wb(); wb_addr = $urandom; wb_start = 1;
    run_bus(0, 1, 0, NB - 1, 2'b10, -1);
    vectors++;
    if (wb_err_obs !== 1'b1 || wb_done_cyc != NB + 3) begin
      miscompares++; $display("FAIL wb_slverr: err=%b done_cycle=%0d want 1/%0d", wb_err_obs, wb_done_cyc, NB + 3);
    end
    for (int i = 0; i < NB; i++) rword[i] = ~exp_line[i];
    rf_addr = $urandom; rf_start = 1;
    run_bus(0, 0, 1, 10, 2'b00, -1);
    for (int k = 0; k < rbeats_sent; k++) exp_line[k] = rword[k];
    vectors++;
    if (rf_done_cyc != 13 || rf_err_obs !== 1'b1) begin
      miscompares++; $display("FAIL rf_short: done_cycle=%0d err=%b want 13/1", rf_done_cyc, rf_err_obs);
    end
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (rf_data[i*DS +: DS] !== exp_line[i]) begin miscompares++; $display("FAIL rf_short_word[%0d]: got %h want %h", i, rf_data[i*DS +: DS], exp_line[i]); end
    end
    vectors++;
    if (rf_err !== 1'b1 || wb_err !== 1'b1) begin miscompares++; $display("FAIL err_hold: rf_err=%b wb_err=%b want 1/1", rf_err, wb_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NB; i++) wb_words[i] = $urandom;
    load_wb(); wb_addr = $urandom; wb_start = 1;
    run_bus(0, 1, 0, NB - 1, 2'b00, 20);
    vectors++;
    if (timeout || wr_seen.size() != 20) begin miscompares++; $display("FAIL mid_reach: beats=%0d timeout=%0d want 20/0", wr_seen.size(), timeout); end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({busy, awvalid, wvalid, wlast, bready, arvalid, rready, wb_done, rf_done, wb_err, rf_err} !== 11'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl: got %b want 0", {busy, awvalid, wvalid, wlast, bready, arvalid, rready, wb_done, rf_done, wb_err, rf_err});
    end
    vectors++;
    if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || rf_data !== '0) begin
      miscompares++; $display("FAIL mid_reset_data: awaddr=%h araddr=%h wdata=%h rf_nonzero=%b want 0", awaddr, araddr, wdata, |rf_data);
    end
    for (int i = 0; i < NB; i++) exp_line[i] = '0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run_mixed(0, 0, "post_reset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_writeback();
    test_refill();
    test_simultaneous();
    test_random_stalls();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
